// File: rtl/rob_pkg.sv
// rob_pkg: tag type and wrapping pointer increment shared by the reorder-buffer control
package rob_pkg;
    localparam int rob_depth = 32;
    typedef logic [$clog2(rob_depth)-1:0] rob_tag_t;
    function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned depth);
        return (p >= depth - 1) ? 0 : p + 1;
    endfunction
endpackage

// File: rtl/rob_ptr_ctr.sv
// rob_ptr_ctr: pointer register that advances on en and wraps at p_depth-1
module rob_ptr_ctr
    import rob_pkg::*;
#(
    parameter int p_depth    = 32,
    parameter int p_ptrwidth = $clog2(p_depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    output logic [p_ptrwidth-1:0] ptr
);
    always_ff @(posedge clk)
        if (!rst || clr) ptr <= '0;
        else if (en) ptr <= p_ptrwidth'(ptr_inc(32'(ptr), p_depth));
endmodule

// File: rtl/rob_reg_ctrl.sv
// rob_reg_ctrl: in-order reorder-buffer control over an external register collection; flush port with ROB_CTRL_FLUSH_EN
module rob_reg_ctrl
    import rob_pkg::*;
#(
    parameter int p_depth    = 32,
    parameter int p_ptrwidth = $clog2(p_depth),
    parameter int p_bitwidth = 32
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ROB_CTRL_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  alloc_val,
    output logic                  alloc_rdy,
    output logic [p_ptrwidth-1:0] alloc_tag,
    input  logic                  wb_val,
    input  logic [p_ptrwidth-1:0] wb_tag,
    input  logic [p_bitwidth-1:0] wb_data,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    output logic [p_bitwidth-1:0] deq_data,
    output logic [p_ptrwidth:0]   count,
    output logic [p_depth-1:0]    wr_data,
    output logic [p_bitwidth-1:0] wr_data_in,
    input  logic [p_bitwidth-1:0] data_out [p_depth],
    output logic [p_depth-1:0]    clr_occ,
    input  logic [p_depth-1:0]    occ
);
    localparam logic [p_ptrwidth:0] depth_c = (p_ptrwidth+1)'(p_depth);
    logic [p_ptrwidth-1:0] head;
    logic [p_ptrwidth:0]   off;
    logic fl, alloc_fire, deq_fire, wb_ok, wb_err;
`ifdef ROB_CTRL_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif
    rob_ptr_ctr #(.p_depth(p_depth), .p_ptrwidth(p_ptrwidth)) u_head (
        .clk(clk), .rst(rst), .clr(fl), .en(deq_fire), .ptr(head)
    );
    rob_ptr_ctr #(.p_depth(p_depth), .p_ptrwidth(p_ptrwidth)) u_tail (
        .clk(clk), .rst(rst), .clr(fl), .en(alloc_fire), .ptr(alloc_tag)
    );
    // off is the tag's distance from head modulo depth; the tag is live iff off < count
    always_comb begin
        alloc_rdy  = !fl && count < depth_c;
        deq_val    = !fl && count != '0 && occ[head];
        deq_data   = data_out[head];
        alloc_fire = alloc_val && alloc_rdy;
        deq_fire   = deq_val && deq_rdy;
        off        = wb_tag >= head ? {1'b0, wb_tag} - {1'b0, head}
                                    : {1'b0, wb_tag} + depth_c - {1'b0, head};
        wb_ok      = rst && !fl && wb_val && int'(wb_tag) < p_depth && off < count && !occ[wb_tag];
        wr_data    = wb_ok ? p_depth'(1) << wb_tag : '0;
        wr_data_in = wb_data;
        clr_occ    = !rst ? '0 : fl ? '1 : deq_fire ? p_depth'(1) << head : '0;
    end
    always_ff @(posedge clk)
        if (!rst || fl) count <= '0;
        else if (alloc_fire != deq_fire) count <= alloc_fire ? count + 1'b1 : count - 1'b1;
    always_ff @(posedge clk)
        if (!rst) wb_err <= 1'b0;
        else if (!fl && wb_val && !wb_ok) wb_err <= 1'b1;
    cover property (@(posedge clk) wb_err);
endmodule

// File: tb/tb_rob_reg_ctrl.sv
// tb_rob_reg_ctrl: directed and randomized checks of rob_reg_ctrl against a queue-based reference model
module tb_rob_reg_ctrl;
    localparam int D  = 5;
    localparam int PW = 3;
    localparam int BW = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic alloc_val, wb_val, deq_rdy, alloc_rdy, deq_val;
    logic [PW-1:0] wb_tag, alloc_tag;
    logic [BW-1:0] wb_data, deq_data, wr_data_in;
    logic [PW:0]   count;
    logic [D-1:0]  wr_data, clr_occ, occ;
    logic [BW-1:0] mem [D];
`ifdef ROB_CTRL_FLUSH_EN
    logic flush = 1'b0;
`endif
    int q[$];
    bit wrt [D];
    logic [BW-1:0] val [D];
    int nxt;
    bit err_exp;
    int checks, errors;

    rob_reg_ctrl #(.p_depth(D), .p_ptrwidth(PW), .p_bitwidth(BW)) dut (
        .clk(clk), .rst(rst),
`ifdef ROB_CTRL_FLUSH_EN
        .flush(flush),
`endif
        .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_tag(alloc_tag),
        .wb_val(wb_val), .wb_tag(wb_tag), .wb_data(wb_data),
        .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_data(deq_data),
        .count(count), .wr_data(wr_data), .wr_data_in(wr_data_in),
        .data_out(mem), .clr_occ(clr_occ), .occ(occ)
    );

    always #5 clk = ~clk;

    // register collection the controller drives
    always_ff @(posedge clk)
        for (int i = 0; i < D; i++)
            if (!rst) occ[i] <= 1'b0;
            else if (clr_occ[i]) occ[i] <= 1'b0;
            else if (wr_data[i]) begin
                occ[i] <= 1'b1;
                mem[i] <= wr_data_in;
            end

    function automatic bit in_q(int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        alloc_val = 0; wb_val = 0; deq_rdy = 0; wb_tag = '0; wb_data = '0;
    endtask

    // advance one clock, applying the same inputs to the reference model
    task automatic tick();
        bit a, d, w, act;
        int t;
        act = rst;
`ifdef ROB_CTRL_FLUSH_EN
        act = act && !flush;
`endif
        t = int'(wb_tag);
        a = act && alloc_val && q.size() < D;
        d = act && q.size() > 0 && wrt[q[0]] && deq_rdy;
        w = act && wb_val && in_q(t) && !wrt[t];
        if (act && wb_val && !w) err_exp = 1'b1;
        @(posedge clk);
        if (!act) begin
            q.delete(); wrt = '{default: 1'b0}; nxt = 0;
            if (!rst) err_exp = 1'b0;
        end else begin
            if (d) begin wrt[q[0]] = 1'b0; void'(q.pop_front()); end
            if (w) begin wrt[t] = 1'b1; val[t] = wb_data; end
            if (a) begin q.push_back(nxt); nxt = (nxt + 1) % D; end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 0; idle(); tick(); rst = 1;
    endtask

    task automatic test_reset();
        rst = 0; idle(); wb_val = 1; deq_rdy = 1; #1;
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL rst_wr_data got %b exp 0", wr_data); end
        checks++; if (clr_occ !== '0) begin errors++; $display("FAIL rst_clr_occ got %b exp 0", clr_occ); end
        tick(); tick(); rst = 1; idle(); #1;
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL rst_alloc_rdy got %b exp 1", alloc_rdy); end
        checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL rst_alloc_tag got %0d exp 0", alloc_tag); end
        checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL rst_deq_val got %b exp 0", deq_val); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 4; i++) begin
            alloc_val = 1; #1;
            checks++; if (alloc_tag !== PW'(i)) begin errors++; $display("FAIL alloc_tag got %0d exp %0d", alloc_tag, i); end
            tick();
        end
        idle(); #1;
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL alloc_count got %0d exp 4", count); end
        checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL alloc_deq_val got %b exp 0", deq_val); end
    endtask

    task automatic test_order();
        wb_val = 1; wb_tag = 3'd2; wb_data = 16'hAA; #1;
        checks++; if (wr_data !== 5'b00100) begin errors++; $display("FAIL order_wr2 got %b exp 00100", wr_data); end
        tick();
        wb_tag = 3'd0; wb_data = 16'h11; #1;
        checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL order_head_not_ready got %b exp 0", deq_val); end
        checks++; if (wr_data !== 5'b00001) begin errors++; $display("FAIL order_wr0 got %b exp 00001", wr_data); end
        tick();
        wb_tag = 3'd1; wb_data = 16'h22; deq_rdy = 1; #1;
        checks++; if (deq_val !== 1'b1 || deq_data !== 16'h11) begin errors++; $display("FAIL order_first got %b/%h exp 1/11", deq_val, deq_data); end
        checks++; if (clr_occ !== 5'b00001) begin errors++; $display("FAIL order_clr got %b exp 00001", clr_occ); end
        tick();
        wb_val = 0; #1;
        checks++; if (deq_val !== 1'b1 || deq_data !== 16'h22) begin errors++; $display("FAIL order_second got %b/%h exp 1/22", deq_val, deq_data); end
        tick(); #1;
        checks++; if (deq_val !== 1'b1 || deq_data !== 16'hAA) begin errors++; $display("FAIL order_third got %b/%h exp 1/aa", deq_val, deq_data); end
        tick(); idle(); #1;
        checks++; if (count !== 4'd1 || deq_val !== 1'b0) begin errors++; $display("FAIL order_left got %0d/%b exp 1/0", count, deq_val); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < D; i++) begin alloc_val = 1; tick(); end
        wb_val = 1; wb_tag = 3'd0; wb_data = 16'h55; #1;
        checks++; if (alloc_rdy !== 1'b0 || count !== 4'd5) begin errors++; $display("FAIL full_rdy got %b/%0d exp 0/5", alloc_rdy, count); end
        tick();
        wb_val = 0; deq_rdy = 1; #1;
        checks++; if (alloc_tag !== 3'd0 || deq_val !== 1'b1 || deq_data !== 16'h55) begin errors++; $display("FAIL full_head_tail got %0d/%b/%h exp 0/1/55", alloc_tag, deq_val, deq_data); end
        checks++; if (alloc_rdy !== 1'b0) begin errors++; $display("FAIL full_no_bypass got %b exp 0", alloc_rdy); end
        tick();
        deq_rdy = 0; #1;
        checks++; if (count !== 4'd4 || alloc_tag !== 3'd0 || alloc_rdy !== 1'b1) begin errors++; $display("FAIL full_after got %0d/%0d/%b exp 4/0/1", count, alloc_tag, alloc_rdy); end
        tick(); idle(); #1;
        checks++; if (count !== 4'd5 || alloc_tag !== 3'd1) begin errors++; $display("FAIL full_wrap got %0d/%0d exp 5/1", count, alloc_tag); end
    endtask

    task automatic test_bad_wb();
        do_reset();
        alloc_val = 1; tick(); tick(); idle();
        wb_val = 1; wb_tag = 3'd3; wb_data = 16'h33; #1;
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL bad_unalloc got %b exp 0", wr_data); end
        tick();
        wb_tag = 3'd1; wb_data = 16'h44; #1;
        checks++; if (dut.wb_err !== 1'b1) begin errors++; $display("FAIL bad_err got %b exp 1", dut.wb_err); end
        checks++; if (wr_data !== 5'b00010) begin errors++; $display("FAIL bad_good_wr got %b exp 00010", wr_data); end
        tick();
        wb_data = 16'h99; #1;
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL bad_dup got %b exp 0", wr_data); end
        tick();
        wb_tag = 3'd0; wb_data = 16'h01; tick();
        wb_val = 0; deq_rdy = 1; #1;
        checks++; if (deq_data !== 16'h01) begin errors++; $display("FAIL bad_deq0 got %h exp 01", deq_data); end
        tick(); #1;
        checks++; if (deq_val !== 1'b1 || deq_data !== 16'h44) begin errors++; $display("FAIL bad_deq1 got %b/%h exp 1/44", deq_val, deq_data); end
        tick(); idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_val = 1; tick(); tick(); tick(); idle();
        wb_val = 1; wb_tag = 3'd0; wb_data = 16'h10; tick();
        wb_tag = 3'd1; wb_data = 16'h20; tick();
        idle(); rst = 0; tick(); rst = 1; #1;
        checks++; if (count !== 4'd0 || alloc_tag !== 3'd0 || deq_val !== 1'b0) begin errors++; $display("FAIL mid_rst got %0d/%0d/%b exp 0/0/0", count, alloc_tag, deq_val); end
        wb_val = 1; wb_tag = 3'd0; #1;
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL mid_rst_wb got %b exp 0", wr_data); end
        tick(); idle(); #1;
        checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL mid_rst_retire got %b exp 0", deq_val); end
    endtask

`ifdef ROB_CTRL_FLUSH_EN
    task automatic test_flush();
        do_reset();
        alloc_val = 1; tick(); tick(); tick(); idle();
        wb_val = 1; wb_tag = 3'd0; tick(); wb_tag = 3'd1; tick();
        wb_tag = 3'd2; flush = 1; alloc_val = 1; #1;
        checks++; if (clr_occ !== 5'b11111) begin errors++; $display("FAIL flush_clr got %b exp 11111", clr_occ); end
        checks++; if (alloc_rdy !== 1'b0 || deq_val !== 1'b0 || wr_data !== '0) begin errors++; $display("FAIL flush_gate got %b/%b/%b exp 0/0/0", alloc_rdy, deq_val, wr_data); end
        tick(); flush = 0; idle(); #1;
        checks++; if (count !== 4'd0 || alloc_tag !== 3'd0) begin errors++; $display("FAIL flush_after got %0d/%0d exp 0/0", count, alloc_tag); end
        alloc_val = 1; tick(); tick(); idle();
        flush = 1; rst = 0; #1;
        checks++; if (clr_occ !== '0) begin errors++; $display("FAIL flush_rst_clr got %b exp 0", clr_occ); end
        tick(); flush = 0; rst = 1; #1;
        checks++; if (count !== 4'd0 || alloc_rdy !== 1'b1) begin errors++; $display("FAIL flush_rst got %0d/%b exp 0/1", count, alloc_rdy); end
    endtask
`endif

    task automatic test_random();
        logic [D-1:0] ew, ec;
        bit ev;
        int t;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) != 0);
            alloc_val = ($urandom_range(0, 2) == 0);
            deq_rdy = ($urandom_range(0, 2) != 0);
            wb_val = $urandom_range(0, 1);
            t = (q.size() > 0 && $urandom_range(0, 2) != 0) ? q[$urandom_range(0, q.size() - 1)] : $urandom_range(0, 7);
            wb_tag = PW'(t);
            wb_data = BW'($urandom);
            #1;
            ev = q.size() > 0 && wrt[q[0]];
            ew = (rst && wb_val && in_q(t) && !wrt[t]) ? D'(1) << t : '0;
            ec = (rst && ev && deq_rdy) ? D'(1) << q[0] : '0;
            checks++; if (alloc_rdy !== (q.size() < D)) begin errors++; $display("FAIL rnd_alloc_rdy n=%0d got %b exp %b", n, alloc_rdy, q.size() < D); end
            checks++; if (alloc_tag !== PW'(nxt)) begin errors++; $display("FAIL rnd_alloc_tag n=%0d got %0d exp %0d", n, alloc_tag, nxt); end
            checks++; if (count !== (PW+1)'(q.size())) begin errors++; $display("FAIL rnd_count n=%0d got %0d exp %0d", n, count, q.size()); end
            checks++; if (deq_val !== ev) begin errors++; $display("FAIL rnd_deq_val n=%0d got %b exp %b", n, deq_val, ev); end
            if (ev) begin
                checks++; if (deq_data !== val[q[0]]) begin errors++; $display("FAIL rnd_deq_data n=%0d got %h exp %h", n, deq_data, val[q[0]]); end
            end
            checks++; if (wr_data !== ew) begin errors++; $display("FAIL rnd_wr_data n=%0d got %b exp %b", n, wr_data, ew); end
            checks++; if (clr_occ !== ec) begin errors++; $display("FAIL rnd_clr_occ n=%0d got %b exp %b", n, clr_occ, ec); end
            checks++; if (dut.wb_err !== err_exp) begin errors++; $display("FAIL rnd_wb_err n=%0d got %b exp %b", n, dut.wb_err, err_exp); end
            tick();
        end
        rst = 1; idle();
    endtask

    initial begin
        checks = 0; errors = 0; nxt = 0; err_exp = 0;
        test_reset();
        test_alloc();
        test_order();
        test_full();
        test_bad_wb();
        test_reset_mid();
`ifdef ROB_CTRL_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
